register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 32, the width of each register and data port.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 5, the address width, giving 2**ADDR_WIDTH registers.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  input  1  clock; all writes on rising edge
- reset  input  1  asynchronous active-high reset
- wen  input  1  write enable
- waddr  input  ADDR_WIDTH  write address
- wdata  input  DATA_WIDTH  write data
- raddr1  input  ADDR_WIDTH  read port 1 address
- rdata1  output  DATA_WIDTH  read port 1 data
- raddr2  input  ADDR_WIDTH  read port 2 address
- rdata2  output  DATA_WIDTH  read port 2 data
- dbg_raddr  input  ADDR_WIDTH  debug/difftest read address
- dbg_rdata  output  DATA_WIDTH  debug read data

Function
REQ-004 The block SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-005 Register 0 SHALL be hardwired to zero: it reads as all-zeros on every port, and writes to it are discarded.
REQ-006 Writes SHALL occur on rising clk:
- when wen=1, reset=0 and waddr!=0, the register at waddr takes wdata;
- otherwise no register changes.
REQ-007 All three read ports SHALL be purely combinational, with zero latency, so each rdata follows its raddr and the register contents within the same cycle.
REQ-008 There SHALL be no write-to-read bypass: a read of the address being written returns the old value until the rising edge, then the new value.
- Required so a single-cycle core can feed rdata through its ALU back into wdata without a combinational loop.
REQ-009 Both read ports MAY address the same register, and each SHALL return the same value.
REQ-010 The ports SHALL be independent: no read port is disturbed by the write port or by the other read ports.
REQ-011 When wen=0, waddr and wdata SHALL be don't-care, and X on them SHALL NOT corrupt any register.

Reset
REQ-012 On assertion of reset, all registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-013 While reset=1:
- all rdata outputs read 0;
- writes are blocked, even if wen=1 on a rising edge.
REQ-014 If reset asserts in the same cycle as a write, reset SHALL win and the register SHALL be 0.
REQ-015 After reset deasserts, the first rising clk with wen=1 SHALL write normally.

Configuration
REQ-016 With macro REGFILE_TRACE_EN defined, the block SHALL print one simulation line per committed write, giving waddr and wdata in hex, on the write edge.
- Writes to register 0 and blocked writes print nothing.
REQ-017 With REGFILE_TRACE_EN undefined, the block SHALL contain no display code, and its functional behaviour SHALL be identical.

Verification
REQ-018 Reset check: pulse reset mid-cycle with no clock edge, then read all 32 addresses on rdata1 -> every read returns 0x00000000.
REQ-019 Write then read: write waddr=5, wdata=0x80000004, wen=1, then on the next cycle set raddr1=5, raddr2=5 -> both ports return 0x80000004.
REQ-020 Register 0: write waddr=0, wdata=0xFFFFFFFF -> rdata1 with raddr1=0 returns 0x00000000.
REQ-021 No bypass: with reg 3 = 0x11 and raddr1=3, drive wen=1, waddr=3, wdata=0x22 -> rdata1 is 0x11 before the edge and 0x22 after it.
REQ-022 Enable and reset priority:
- wen=0, waddr=7, wdata=0x1234 -> reg 7 is unchanged.
- reset asserted alongside wen=1, waddr=7 -> reg 7 is 0.
REQ-023 Port independence: raddr1=1, raddr2=2, dbg_raddr=31 holding 0xA, 0xB and 0xC -> the ports return 0xA, 0xB and 0xC simultaneously.

Source files
------------

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   General-purpose register file for a single-cycle core. It provides
//   2**ADDR_WIDTH registers of DATA_WIDTH bits, one synchronous write port,
//   two combinational operand read ports, and a combinational debug read port.
//   Register 0 is hardwired to zero. There is no write-to-read bypass, so read
//   data can be fed through the ALU back into wdata without forming a
//   combinational loop.
//
// Parameters:
//   DATA_WIDTH  width of each register and of every data port (default 32)
//   ADDR_WIDTH  address width; the file holds 2**ADDR_WIDTH registers (default 5)
//
// Ports:
//   clk        in   1           clock; writes commit on the rising edge
//   reset      in   1           asynchronous active-high reset; clears all registers
//   wen        in   1           write enable
//   waddr      in   ADDR_WIDTH  write address
//   wdata      in   DATA_WIDTH  write data
//   raddr1     in   ADDR_WIDTH  read port 1 address
//   rdata1     out  DATA_WIDTH  read port 1 data (combinational)
//   raddr2     in   ADDR_WIDTH  read port 2 address
//   rdata2     out  DATA_WIDTH  read port 2 data (combinational)
//   dbg_raddr  in   ADDR_WIDTH  debug/difftest read address
//   dbg_rdata  out  DATA_WIDTH  debug read data (combinational)
//
// Build option:
//   REGFILE_TRACE_EN  when defined, prints one simulation line per committed
//                     write (address and data in hex). When undefined, the
//                     module contains no display code at all.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  write_commit;

  // A write only takes effect when enabled, out of reset, and aimed at a
  // register other than the hardwired zero register.
  always_comb begin
    write_commit = wen && !reset && (waddr != '0);
  end

  // Storage. Reset clears every register asynchronously, so reads drop to
  // zero immediately and any write coinciding with reset loses. Register 0
  // is never written outside reset, so it holds zero permanently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_commit) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports are plain muxes onto the stored state with no bypass from the
  // write port. Address 0 is forced to zero explicitly so the zero register
  // does not depend on the storage element holding its reset value.
  always_comb begin
    rdata1    = (raddr1 == '0)    ? '0 : regs[raddr1];
    rdata2    = (raddr2 == '0)    ? '0 : regs[raddr2];
    dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
  end

`ifdef REGFILE_TRACE_EN
  // Simulation trace of every committed write, reported on the write edge.
  always @(posedge clk) begin
    if (write_commit) begin
      $display("[REGFILE] write x%0d <= 0x%h", waddr, wdata);
    end
  end
`else
`endif

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Purpose:
//   Self-checking testbench for register_file (default 32 x 32 configuration).
//   Directed steps cover reset, write/read, the zero register, the absence of
//   a bypass, enable and reset priority, and port independence. These are
//   followed by randomized traffic checked against an array model of the
//   register contents.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic          clk;
  logic          reset;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic [AW-1:0] dbg_raddr;
  logic [DW-1:0] dbg_rdata;

  int vectors;
  int miscompares;

  // Reference contents: what each architectural register should hold.
  logic [DW-1:0] model [NR];

  register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] modelRead(input logic [AW-1:0] addr);
    return (addr == 0) ? '0 : model[addr];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
    wen   = we;
    waddr = wa;
    wdata = wd;
  endtask

  // Advance one cycle from a falling edge to the next falling edge, applying
  // the write rule to the model at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (!reset && wen === 1'b1 && waddr != 0) model[waddr] = wdata;
    @(negedge clk);
  endtask

  task automatic writeReg(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    applyStimulus(1'b1, wa, wd);
    tick();
    applyStimulus(1'b0, '0, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clearModel();
    reset     = 1'b1;
    applyStimulus(1'b0, '0, '0);
    raddr1    = '0;
    raddr2    = '0;
    dbg_raddr = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_rdata1", rdata1, '0);
    reset = 1'b0;
    @(negedge clk);

    // Fill every register with random data.
    for (int i = 1; i < NR; i++) writeReg(AW'(i), $urandom);
    raddr1 = 5'd9;
    raddr2 = 5'd20;
    #1;
    checkOutput("fill_r9",  rdata1, modelRead(5'd9));
    checkOutput("fill_r20", rdata2, modelRead(5'd20));
    @(negedge clk);

    // Mid-cycle reset pulse with no clock edge inside it.
    #1 reset = 1'b1;
    raddr1    = 5'd9;
    raddr2    = 5'd20;
    dbg_raddr = 5'd31;
    #1;
    checkOutput("inreset_rdata1", rdata1, '0);
    checkOutput("inreset_rdata2", rdata2, '0);
    checkOutput("inreset_dbg",    dbg_rdata, '0);
    reset = 1'b0;
    clearModel();
    for (int i = 0; i < NR; i++) begin
      raddr1 = AW'(i);
      #1;
      checkOutput($sformatf("postreset_r%0d", i), rdata1, 32'h0);
    end
    @(negedge clk);

    // Write then read on both ports.
    writeReg(5'd5, 32'h8000_0004);
    raddr1 = 5'd5;
    raddr2 = 5'd5;
    #1;
    checkOutput("wr5_rdata1", rdata1, 32'h8000_0004);
    checkOutput("wr5_rdata2", rdata2, 32'h8000_0004);

    // Writes to register 0 are discarded.
    writeReg(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    dbg_raddr = 5'd0;
    #1;
    checkOutput("r0_rdata1", rdata1, 32'h0);
    checkOutput("r0_dbg",    dbg_rdata, 32'h0);

    // No bypass: old value until the edge, new value after.
    writeReg(5'd3, 32'h11);
    raddr1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 32'h22);
    #1;
    checkOutput("nobypass_before", rdata1, 32'h11);
    @(posedge clk);
    #1;
    checkOutput("nobypass_after", rdata1, 32'h22);
    @(negedge clk);
    model[3] = 32'h22;
    applyStimulus(1'b0, '0, '0);

    // Disabled write with don't-care address/data leaves registers alone.
    writeReg(5'd7, 32'h5A5A_0007);
    applyStimulus(1'b0, 5'd7, 32'h1234);
    tick();
    applyStimulus(1'b0, 'x, 'x);
    tick();
    dbg_raddr = 5'd7;
    #1;
    checkOutput("wen0_r7", dbg_rdata, 32'h5A5A_0007);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);

    // Reset coinciding with a write: reset wins.
    applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    clearModel();
    @(posedge clk);
    #1;
    checkOutput("rstwin_r7", dbg_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0);
    #1;
    checkOutput("rstwin_r7_after", dbg_rdata, 32'h0);

    // First enabled write after reset commits normally.
    writeReg(5'd7, 32'h0000_0077);
    #1;
    checkOutput("postrst_write_r7", dbg_rdata, 32'h0000_0077);

    // Port independence.
    writeReg(5'd1, 32'hA);
    writeReg(5'd2, 32'hB);
    writeReg(5'd31, 32'hC);
    raddr1 = 5'd1;
    raddr2 = 5'd2;
    dbg_raddr = 5'd31;
    applyStimulus(1'b1, 5'd2, 32'hFFFF_0000);
    #1;
    checkOutput("indep_rdata1", rdata1, 32'hA);
    checkOutput("indep_rdata2", rdata2, 32'hB);
    checkOutput("indep_dbg",    dbg_rdata, 32'hC);
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      raddr1    = AW'($urandom);
      raddr2    = ($urandom_range(0, 3) == 0) ? raddr1 : AW'($urandom);
      dbg_raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
      #1;
      checkOutput("rand_rdata1", rdata1, modelRead(raddr1));
      checkOutput("rand_rdata2", rdata2, modelRead(raddr2));
      checkOutput("rand_dbg",    dbg_rdata, modelRead(dbg_raddr));
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < NR; i++) begin
      dbg_raddr = AW'(i);
      #1;
      checkOutput($sformatf("final_r%0d", i), dbg_rdata, modelRead(AW'(i)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
